// File: rtl/rfs_ring_pkg.sv
// Shared types and constants for the sample ring writer: pack FSM states,
// byte-lane masks and the packed-word FIFO entry layout.
package rfs_ring_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_LOW  = 4'b0011;

  typedef struct packed {
    logic [3:0]  byteenable;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rfs_word_fifo.sv
// Small synchronous FIFO of packed memory words; the head entry is visible
// combinationally so the master can present it without an extra cycle.
module rfs_word_fifo
  import rfs_ring_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        push_i,
  input  fifo_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output fifo_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t    mem_q [DEPTH];
  logic [AW:0]    wr_q, wr_d;
  logic [AW:0]    rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + (AW+1)'(1);
      if (pop_i)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // When full, the write slot is the head slot; a same-cycle pop frees it first.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q[AW-1:0]] <= push_entry_i;
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/rfs_sample_ring_writer.sv
// Packs 16-bit samples into 32-bit words and writes them round a circular
// buffer through a write-only Avalon-MM master, with status for software.
module rfs_sample_ring_writer
  import rfs_ring_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int ADDR_W      = 15,
  parameter int DEPTH_WORDS = 32000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                snk_valid,
  input  logic [SAMPLE_W-1:0] snk_data,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   m_address,
  output logic [3:0]          m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [31:0]         m_writedata,
  input  logic                m_waitrequest,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic                wrapped,
  output logic [15:0]         overflow_cnt,
  output logic                irq,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] MID_ADDR  = ADDR_W'(DEPTH_WORDS / 2 - 1);

  pack_state_t         state_q, state_d;
  logic [SAMPLE_W-1:0] low_q, low_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                wrapped_q, wrapped_d;
  logic [15:0]         ovf_q, ovf_d;
  logic                irq_q, irq_d;

  logic        fifo_full, fifo_empty;
  logic        push, pop, can_push, accept;
  fifo_entry_t push_entry, head;

  rfs_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head)
  );

  // The FIFO head is the in-flight write; it stays put until the fabric takes it.
  assign m_write      = !fifo_empty;
  assign m_chipselect = m_write;
  assign m_address    = wr_ptr_q;
  assign m_writedata  = m_write ? head.data : 32'h0;
  assign m_byteenable = m_write ? head.byteenable : 4'h0;

  assign pop      = m_write && !m_waitrequest;
  assign can_push = !fifo_full || pop;
  // EMPTY only fills the pack register, so it never needs FIFO room.
  assign snk_ready = !reset && enable && !clear && ((state_q == EMPTY) || can_push);
  assign accept    = snk_valid && snk_ready;

  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    push       = 1'b0;
    push_entry = '0;
    if (!clear) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            low_d   = snk_data;
            state_d = HALF;
          end
        end
        HALF: begin
          if (enable) begin
            if (accept) begin
              push                  = 1'b1;
              push_entry.data       = {snk_data, low_q};
              push_entry.byteenable = BE_FULL;
              state_d               = EMPTY;
            end
          end else if (can_push) begin
            push                  = 1'b1;
            push_entry.data       = {{SAMPLE_W{1'b0}}, low_q};
            push_entry.byteenable = BE_LOW;
            state_d               = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wrapped_d = wrapped_q;
    ovf_d     = ovf_q;
    irq_d     = 1'b0;
    if (clear) begin
      wr_ptr_d  = '0;
      wrapped_d = 1'b0;
      ovf_d     = '0;
    end else begin
      irq_d = pop && ((wr_ptr_q == MID_ADDR) || (wr_ptr_q == LAST_ADDR));
      if (pop) begin
        if (wr_ptr_q == LAST_ADDR) begin
          wr_ptr_d  = '0;
          wrapped_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
      end
      if (enable && snk_valid && !snk_ready && (ovf_q != 16'hFFFF))
        ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      low_q     <= '0;
      wr_ptr_q  <= '0;
      wrapped_q <= 1'b0;
      ovf_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      wr_ptr_q  <= wr_ptr_d;
      wrapped_q <= wrapped_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign wrapped      = wrapped_q;
  assign overflow_cnt = ovf_q;
  assign irq          = irq_q;
  assign busy         = (state_q == HALF) || !fifo_empty;

endmodule
